// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned NrOfBits = 32
);
  logic                start;
  logic [1:0]          op;
  logic [NrOfBits-1:0] a;
  logic [NrOfBits-1:0] b;
  logic                mthi;
  logic                mtlo;
  logic [NrOfBits-1:0] hi;
  logic [NrOfBits-1:0] lo;
  logic                busy;
  logic                done;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO moves.
// op encoding: bit0 = unsigned, bit1 = divide.
module muldiv_unit #(
  parameter int unsigned NrOfBits = 32
) (
  input logic          clock,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned W     = NrOfBits;
  localparam int unsigned CNT_W = $clog2(NrOfBits);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state, w_state_nxt;
  logic [W-1:0]     r_hi, w_hi_nxt;
  logic [W-1:0]     r_lo, w_lo_nxt;
  logic [W-1:0]     r_up, w_up_nxt;      // mult: running upper product; div: partial remainder
  logic [W-1:0]     r_lw, w_lw_nxt;      // mult: multiplier/low product; div: dividend/quotient
  logic [W-1:0]     r_b, w_b_nxt;        // multiplicand / divisor magnitude
  logic             r_is_div, w_is_div_nxt;
  logic             r_neg_q, w_neg_q_nxt;
  logic             r_neg_r, w_neg_r_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_move;
  logic             w_signed;
  logic             w_a_neg, w_b_neg, w_b_zero;
  logic [W-1:0]     w_a_mag, w_b_mag;
  logic [W:0]       w_mul_sum;
  logic [W:0]       w_div_shift;
  logic [W-1:0]     w_div_diff;
  logic             w_div_ge;
  logic [W-1:0]     w_up_step, w_lw_step;
  logic [2*W-1:0]   w_prod_mag, w_prod;
  logic [W-1:0]     w_quo, w_rem;

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // Launch-time operand decode: magnitudes and sign flags for signed ops.
  always_comb begin
    w_move   = bus.mthi | bus.mtlo;
    w_signed = ~bus.op[0];
    w_a_neg  = w_signed & bus.a[W-1];
    w_b_neg  = w_signed & bus.b[W-1];
    w_b_zero = (bus.b == '0);
    w_a_mag  = w_a_neg ? W'(-bus.a) : bus.a;
    w_b_mag  = w_b_neg ? W'(-bus.b) : bus.b;
  end

  // One shift-add or restoring shift-subtract iteration plus sign fix-up of the final value.
  always_comb begin
    w_mul_sum   = {1'b0, r_up} + (r_lw[0] ? {1'b0, r_b} : '0);
    w_div_shift = {r_up, r_lw[W-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    w_div_diff  = W'(w_div_shift - {1'b0, r_b});
    if (r_is_div) begin
      w_up_step = w_div_ge ? w_div_diff : w_div_shift[W-1:0];
      w_lw_step = {r_lw[W-2:0], w_div_ge};
    end else begin
      w_up_step = w_mul_sum[W:1];
      w_lw_step = {w_mul_sum[0], r_lw[W-1:1]};
    end
    w_prod_mag = {w_up_step, w_lw_step};
    w_prod     = r_neg_q ? (2*W)'(-w_prod_mag) : w_prod_mag;
    w_quo      = r_neg_q ? W'(-w_lw_step) : w_lw_step;
    w_rem      = r_neg_r ? W'(-w_up_step) : w_up_step;
  end

  // Next-state and datapath update; moves override HI/LO and abort any run.
  always_comb begin
    w_state_nxt  = r_state;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_up_nxt     = r_up;
    w_lw_nxt     = r_lw;
    w_b_nxt      = r_b;
    w_is_div_nxt = r_is_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !w_move) begin
          w_state_nxt  = S_RUN;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          w_up_nxt     = '0;
          w_lw_nxt     = w_a_mag;
          w_b_nxt      = w_b_mag;
          w_is_div_nxt = bus.op[1];
          // Divide by zero leaves an all-ones quotient; suppressing its negation keeps LO=FFFFFFFF,
          // while the dividend-signed remainder reproduces a on HI.
          w_neg_q_nxt  = (w_a_neg ^ w_b_neg) & ~(bus.op[1] & w_b_zero);
          w_neg_r_nxt  = w_a_neg & bus.op[1];
        end
      end
      S_RUN: begin
        if (w_move) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_up_nxt  = w_up_step;
          w_lw_nxt  = w_lw_step;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            if (r_is_div) begin
              w_hi_nxt = w_rem;
              w_lo_nxt = w_quo;
            end else begin
              w_hi_nxt = w_prod[2*W-1:W];
              w_lo_nxt = w_prod[W-1:0];
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (bus.mthi) w_hi_nxt = bus.a;
    if (bus.mtlo) w_lo_nxt = bus.a;
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_up     <= '0;
      r_lw     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_up     <= w_up_nxt;
      r_lw     <= w_lw_nxt;
      r_b      <= w_b_nxt;
      r_is_div <= w_is_div_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, moves/aborts and reset.
module tb_muldiv_unit;
  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   cyc;

  muldiv_unit_if #(.NrOfBits(32)) bus ();

  muldiv_unit #(.NrOfBits(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present start for one edge (E0), then drop it.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    cyc = 0;
  endtask

  // Wait (bounded) for done; checks latency, busy coverage and the written HI/LO.
  task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el);
    bit dropped;
    dropped = 1'b0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy !== 1'b1) dropped = 1'b1;
      step();
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
    chk({tag, "_busy_held"}, 64'(dropped), 64'd0);
    chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  // Run n cycles and report whether done ever pulsed.
  task automatic watch_no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;

    #2;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // MULT -3 * 7
    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    chk("mult_busy_after_e0", 64'(bus.busy), 64'd1);
    wait_done("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB);
    step();
    chk("mult_done_drop", 64'(bus.done), 64'd0);

    // MULTU max * max
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 32'hFFFFFFFE, 32'h00000001);

    // DIV -7 / 2, then DIVU 100 / 7 launched in the done cycle
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(2'b11, 32'd100, 32'd7);
    wait_done("divu_b2b", 32'd2, 32'd14);

    // DIVU by zero
    launch(2'b11, 32'h12345678, 32'd0);
    wait_done("divu_zero", 32'h12345678, 32'hFFFFFFFF);

    // DIV overflow
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 32'h00000000, 32'h80000000);

    // DIV 7 / -2 -> q=-3, r=1
    launch(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done("div_negb", 32'd1, 32'hFFFFFFFD);

    // DIV -7 / 0 -> LO all ones, HI = a
    launch(2'b10, 32'hFFFFFFF9, 32'd0);
    wait_done("div_zero_neg", 32'hFFFFFFF9, 32'hFFFFFFFF);

    // start while busy is ignored (MULTU 6*7)
    launch(2'b01, 32'd6, 32'd7);
    step();
    step();
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd5;
    bus.b     = 32'd1;
    step();
    bus.start = 1'b0;
    wait_done("start_ignored", 32'd0, 32'd42);

    // MTHI at iteration 5 aborts a MULT
    launch(2'b00, 32'd3, 32'd5);
    for (int i = 0; i < 5; i++) step();
    bus.mthi = 1'b1;
    bus.a    = 32'hCAFEBABE;
    step();
    bus.mthi = 1'b0;
    chk("abort_hi", 64'(bus.hi), 64'h0CAFEBABE);
    chk("abort_lo", 64'(bus.lo), 64'd42);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    watch_no_done("abort_no_done", 40);
    chk("abort_hi_kept", 64'(bus.hi), 64'h0CAFEBABE);
    chk("abort_lo_kept", 64'(bus.lo), 64'd42);

    // MTLO together with start in IDLE: move wins
    bus.mtlo  = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd55;
    bus.b     = 32'd3;
    step();
    bus.mtlo  = 1'b0;
    bus.start = 1'b0;
    chk("mtlo_lo", 64'(bus.lo), 64'd55);
    chk("mtlo_hi", 64'(bus.hi), 64'h0CAFEBABE);
    chk("mtlo_start_busy", 64'(bus.busy), 64'd0);
    watch_no_done("mtlo_start_no_done", 36);

    // MTHI and MTLO together
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.a    = 32'h00001234;
    step();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mtboth_hi", 64'(bus.hi), 64'h1234);
    chk("mtboth_lo", 64'(bus.lo), 64'h1234);

    // Reset mid-RUN at iteration 10
    launch(2'b00, 32'd9, 32'd9);
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    step();
    reset_n = 1'b1;
    watch_no_done("midrst_no_done", 40);
    chk("midrst_hi_after", 64'(bus.hi), 64'd0);
    chk("midrst_lo_after", 64'(bus.lo), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the EX stage of the MIPS pipeline. It takes the same forwarded `a`/`b` operand buses as the ALU logic functions and computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers over 32 cycles. It exposes `busy` to the hazard unit so that MFHI/MFLO and new mult/div instructions stall. HI/LO outputs feed the EX result mux.

## Interface
Parameters:
- `NrOfBits`, 32, operand width; only 32 is supported.

Ports:
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch the operation in `op` using `a`/`b`; sampled on a clock edge.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input 32: rs operand (multiplicand/dividend; also the MTHI/MTLO data).
- `b` input 32: rt operand (multiplier/divisor).
- `mthi` input 1: write `a` to HI.
- `mtlo` input 1: write `a` to LO.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse when HI/LO receive a result.

## Operation
- Reset (asynchronous, `reset_n`=0): `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, iteration counter=0. This applies immediately, including mid-operation. Any in-flight result is discarded.
- States:
  - IDLE: a `start` edge latches operands and `op`, then goes to RUN.
  - RUN: performs 32 iterations. After the last iteration it writes HI/LO and returns to IDLE.
- Operand handling: signed ops (MULT, DIV) convert operands to magnitudes at launch and record the result signs. Unsigned ops use the raw operands.
- Multiply: shift-add, one multiplier bit per cycle. The 64-bit product goes to {HI,LO}. The signed product is negated when the operand signs differ.
- Divide: restoring shift-subtract, one quotient bit per cycle. LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (`b`=0, DIV or DIVU): LO=32'hFFFFFFFF, HI=`a`. Latency is unchanged.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): LO=32'h80000000, HI=0.
- `start` while `busy`=1: ignored. Operands and progress are unaffected.
- `mthi`/`mtlo`:
  - Write HI/LO on the edge they are sampled. Both may be asserted together.
  - If `busy`=1, the in-flight operation is aborted: state goes to IDLE, `busy`=0 next cycle, no `done`, and the result is never written.
  - `mthi`/`mtlo` asserted together with `start` in IDLE: the move wins and `start` is ignored.
- `hi`/`lo` change only on reset, a move, or result write-back. Partial products and remainders live in internal registers and are never visible on `hi`/`lo`.

## Timing
- Launch edge E0 (`start`=1, IDLE): `busy`=1 from after E0.
- Iteration edges: E1..E32.
- Result write: on E32, HI/LO are written, `busy`=0 and `done`=1 after E32. `done` returns to 0 after E33.
- `busy` is high for exactly 32 cycles. A result is readable on `hi`/`lo` in the cycle `done` is high.
- Back-to-back: `start` may be asserted in the `done` cycle and launches on E33.
- `done` never coincides with `busy`=1.
- Move latency: 1 edge. The new value is visible after the sampling edge.

## Test plan
- Reset mid-RUN: launch MULT, then drop `reset_n` at iteration 10 -> `hi`=`lo`=0 and `busy`=`done`=0 immediately. No `done` pulse after release.
- MULT a=32'hFFFFFFFD (−3), b=7 -> after 32 busy cycles, `done` pulses with `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB.
- MULTU a=b=32'hFFFFFFFF -> `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- DIV a=32'hFFFFFFF9 (−7), b=2 -> `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF. Then DIVU a=100, b=7 launched in the `done` cycle -> `lo`=14, `hi`=2 after 32 more cycles.
- DIVU a=32'h12345678, b=0 -> `lo`=32'hFFFFFFFF, `hi`=32'h12345678. DIV 32'h80000000 / 32'hFFFFFFFF -> `lo`=32'h80000000, `hi`=0.
- Abort and ignore checks:
  - Launch MULT, assert `mthi` with a=32'hCAFEBABE at iteration 5 -> `hi`=32'hCAFEBABE, `lo` unchanged, `busy`=0 next cycle, no `done` pulse.
  - `start` during `busy` -> no effect on result or timing.
